// File: rtl/melody_sequencer_if.sv
// Note-queue bus between producers (keypad logic, alarm ROM walker) and the sequencer,
// together with the tone-generator control and status outputs.
interface melody_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             play;
    logic             flush;
    logic [2:0]       octave;
    logic             nOn;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_data, play, flush,
        input  full, count, octave, nOn, busy, done
    );

    modport slave (
        input  wr_en, wr_data, play, flush,
        output full, count, octave, nOn, busy, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Queue-driven note sequencer: plays FIFO entries as tones or rests for a number of beats,
// each followed by a silent articulation gap, with play/pause, flush and a drain-done pulse.
module melody_sequencer #(
    parameter int FRQ      = 1_000_000,
    parameter int BEAT_CYC = FRQ / 8,
    parameter int GAP_CYC  = FRQ / 100,
    parameter int DEPTH    = 16
) (
    input logic               clk,
    input logic               nRst,
    melody_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MAXC  = (BEAT_CYC > GAP_CYC) ? BEAT_CYC : GAP_CYC;
    localparam int CYC_W = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q;
    logic             rest_q;
    logic [4:0]       beats_q;
    logic [4:0]       beat_cnt_q;
    logic [CYC_W-1:0] cycle_cnt_q;
    logic [2:0]       octave_q;
    logic             non_q;
    logic             done_q;

    logic       full_w;
    logic       push;
    logic       pop;
    logic [7:0] head;

    assign full_w = (count_q == CNT_W'(DEPTH));
    // A pop in the same cycle never frees room for a write while full.
    assign push   = bus.wr_en && !full_w && !bus.flush;
    assign pop    = (state_q == LOAD) && !bus.flush;
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            rest_q      <= 1'b0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            octave_q    <= '0;
            non_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q     <= IDLE;
                beat_cnt_q  <= '0;
                cycle_cnt_q <= '0;
                non_q       <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        non_q <= 1'b1;
                        if (bus.play && count_q != '0) state_q <= LOAD;
                    end
                    LOAD: begin
                        rest_q      <= head[7];
                        octave_q    <= head[6:4];
                        beats_q     <= (head[3:0] == 4'd0) ? 5'd16 : {1'b0, head[3:0]};
                        beat_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        non_q       <= head[7];
                        state_q     <= TONE;
                    end
                    TONE: begin
                        // Paused: counters hold and the tone is muted until play returns.
                        if (!bus.play) begin
                            non_q <= 1'b1;
                        end else begin
                            non_q <= rest_q;
                            if (cycle_cnt_q == CYC_W'(BEAT_CYC - 1)) begin
                                cycle_cnt_q <= '0;
                                if (beat_cnt_q == beats_q - 5'd1) begin
                                    beat_cnt_q <= '0;
                                    non_q      <= 1'b1;
                                    state_q    <= GAP;
                                end else begin
                                    beat_cnt_q <= beat_cnt_q + 5'd1;
                                end
                            end else begin
                                cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        non_q <= 1'b1;
                        if (cycle_cnt_q == CYC_W'(GAP_CYC - 1)) begin
                            if (count_q == '0) begin
                                cycle_cnt_q <= '0;
                                done_q      <= 1'b1;
                                state_q     <= IDLE;
                            end else if (bus.play) begin
                                cycle_cnt_q <= '0;
                                state_q     <= LOAD;
                            end
                        end else if (bus.play) begin
                            cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.full   = full_w;
    assign bus.count  = count_q;
    assign bus.octave = octave_q;
    assign bus.nOn    = non_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: scenario tasks compare the DUT against an expected
// per-cycle trace derived from the queued note entries.
module tb_melody_sequencer;
    localparam int BEAT  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nRst;

    melody_sequencer_if #(.DEPTH(DEPTH)) bus ();

    melody_sequencer #(
        .FRQ(1000), .BEAT_CYC(BEAT), .GAP_CYC(GAP), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bit         exp_non[$];
    bit         exp_busy[$];
    bit         exp_done[$];
    bit         exp_ochk[$];
    logic [2:0] exp_oct[$];
    logic [7:0] push_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_row(input bit n, input bit bz, input bit d, input bit oc, input logic [2:0] o);
        exp_non.push_back(n);
        exp_busy.push_back(bz);
        exp_done.push_back(d);
        exp_ochk.push_back(oc);
        exp_oct.push_back(o);
    endtask

    // Expected observations starting the cycle after the sequencer is triggered:
    // LOAD, beats*BEAT tone/rest cycles, GAP silent cycles per entry, then the done cycle.
    task automatic build_expect(input logic [7:0] ents[$]);
        exp_non = {}; exp_busy = {}; exp_done = {}; exp_ochk = {}; exp_oct = {};
        foreach (ents[k]) begin
            int b;
            b = (ents[k][3:0] == 4'd0) ? 16 : int'(ents[k][3:0]);
            add_row(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            for (int c = 0; c < b * BEAT; c++) add_row(ents[k][7], 1'b1, 1'b0, 1'b1, ents[k][6:4]);
            for (int g = 0; g < GAP; g++)      add_row(1'b1, 1'b1, 1'b0, 1'b1, ents[k][6:4]);
        end
        add_row(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic check_trace(input int start, input string name);
        for (int i = start; i < exp_non.size(); i++) begin
            if (push_q.size() > 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = push_q.pop_front();
            end
            tick();
            bus.wr_en = 1'b0;
            vectors++;
            if (bus.nOn !== exp_non[i]) begin
                miscompares++;
                $display("FAIL %s nOn cyc %0d: got %b want %b", name, i, bus.nOn, exp_non[i]);
            end
            vectors++;
            if (bus.busy !== exp_busy[i]) begin
                miscompares++;
                $display("FAIL %s busy cyc %0d: got %b want %b", name, i, bus.busy, exp_busy[i]);
            end
            vectors++;
            if (bus.done !== exp_done[i]) begin
                miscompares++;
                $display("FAIL %s done cyc %0d: got %b want %b", name, i, bus.done, exp_done[i]);
            end
            if (exp_ochk[i]) begin
                vectors++;
                if (bus.octave !== exp_oct[i]) begin
                    miscompares++;
                    $display("FAIL %s octave cyc %0d: got %0d want %0d", name, i, bus.octave, exp_oct[i]);
                end
            end
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b1;
        #1 nRst = 1'b0;
        #2;
        vectors++; if (bus.nOn !== 1'b1)   begin miscompares++; $display("FAIL reset nOn: got %b want 1", bus.nOn); end
        vectors++; if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0)  begin miscompares++; $display("FAIL reset done: got %b want 0", bus.done); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", bus.count); end
        vectors++; if (bus.full !== 1'b0)  begin miscompares++; $display("FAIL reset full: got %b want 0", bus.full); end
        vectors++; if (bus.octave !== 3'd0) begin miscompares++; $display("FAIL reset octave: got %0d want 0", bus.octave); end
        tick();
        nRst = 1'b1;
        tick();
        bus.play = 1'b1;
        push_one(8'h13);
        push_one(8'h24);
        tick();
        tick();
        vectors++; if (bus.nOn !== 1'b0)   begin miscompares++; $display("FAIL midrun nOn: got %b want 0", bus.nOn); end
        vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL midrun count: got %0d want 1", bus.count); end
        nRst = 1'b0;
        #1;
        vectors++; if (bus.nOn !== 1'b1)   begin miscompares++; $display("FAIL async_reset nOn: got %b want 1", bus.nOn); end
        vectors++; if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL async_reset busy: got %b want 0", bus.busy); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL async_reset count: got %0d want 0", bus.count); end
        vectors++; if (bus.full !== 1'b0)  begin miscompares++; $display("FAIL async_reset full: got %b want 0", bus.full); end
        tick();
        tick();
        nRst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] e[$];
        e = {8'h12};
        bus.play = 1'b1;
        push_one(8'h12);
        vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL single count: got %0d want 1", bus.count); end
        vectors++; if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL single busy: got %b want 0", bus.busy); end
        push_q = {};
        build_expect(e);
        check_trace(0, "single");
    endtask

    task automatic test_chain();
        logic [7:0] e[$];
        e = {8'h81, 8'h51};
        bus.play = 1'b1;
        push_one(8'h81);
        push_q = {8'h51};
        build_expect(e);
        check_trace(0, "chain");
    endtask

    task automatic test_full();
        logic [7:0] e[$];
        e = {8'h11, 8'h21, 8'h31, 8'h41, 8'h71};
        bus.play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(e[i]);
            vectors++;
            if (bus.count !== 3'((i < 4) ? i + 1 : 4)) begin
                miscompares++;
                $display("FAIL full_fill count after %0d: got %0d want %0d", i, bus.count, (i < 4) ? i + 1 : 4);
            end
            vectors++;
            if (bus.full !== (i >= 3)) begin
                miscompares++;
                $display("FAIL full_fill full after %0d: got %b want %b", i, bus.full, (i >= 3));
            end
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        bus.play    = 1'b1;
        tick();
        vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL full_start count: got %0d want 4", bus.count); end
        tick();
        bus.wr_en = 1'b0;
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL full_pop count: got %0d want 3", bus.count); end
        vectors++; if (bus.full !== 1'b0)  begin miscompares++; $display("FAIL full_pop full: got %b want 0", bus.full); end
        e.pop_back();
        push_q = {};
        build_expect(e);
        check_trace(2, "full");
    endtask

    task automatic test_pause();
        logic [7:0] e[$];
        e = {8'h12, 8'h31};
        bus.play = 1'b0;
        push_one(8'h12);
        push_one(8'h31);
        bus.play = 1'b1;
        tick();
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL pause load busy: got %b want 1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.nOn !== 1'b0 || bus.octave !== 3'd1) begin
                miscompares++;
                $display("FAIL pause pre tone %0d: got nOn=%b oct=%0d want nOn=0 oct=1", i, bus.nOn, bus.octave);
            end
        end
        bus.play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (bus.nOn !== 1'b1 || bus.count !== 3'd1 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL pause hold %0d: got nOn=%b count=%0d busy=%b want 1,1,1", i, bus.nOn, bus.count, bus.busy);
            end
        end
        bus.play = 1'b1;
        push_q = {};
        build_expect(e);
        check_trace(4, "pause");
    endtask

    task automatic test_flush();
        logic [7:0] e[$];
        bus.play = 1'b0;
        push_one(8'h12);
        push_one(8'h23);
        push_one(8'h34);
        push_one(8'h45);
        bus.play = 1'b1;
        tick();
        tick();
        tick();
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL flush pre count: got %0d want 3", bus.count); end
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h56;
        tick();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        vectors++; if (bus.busy !== 1'b0)  begin miscompares++; $display("FAIL flush busy: got %b want 0", bus.busy); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL flush count: got %0d want 0", bus.count); end
        vectors++; if (bus.nOn !== 1'b1)   begin miscompares++; $display("FAIL flush nOn: got %b want 1", bus.nOn); end
        vectors++; if (bus.done !== 1'b0)  begin miscompares++; $display("FAIL flush done: got %b want 0", bus.done); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL flush idle %0d: got done=%b busy=%b want 0,0", i, bus.done, bus.busy);
            end
        end
        e = {8'h60};
        push_one(8'h60);
        push_q = {};
        build_expect(e);
        check_trace(0, "beats0");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] e[$];
            int n;
            logic       r;
            logic [2:0] nt;
            logic [3:0] bt;
            e = {};
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                r  = ($urandom_range(0, 3) == 0);
                nt = 3'($urandom_range(0, 7));
                bt = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                e.push_back({r, nt, bt});
            end
            bus.play = 1'b1;
            push_one(e[0]);
            push_q = {};
            for (int k = 1; k < n; k++) push_q.push_back(e[k]);
            build_expect(e);
            check_trace(0, "random");
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.play    = 1'b0;
        bus.flush   = 1'b0;
        test_reset();
        test_single();
        test_chain();
        test_full();
        test_pause();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
